if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and produces the get_inst / if_pc / if_inst stream that the IF/ID pipeline register consumes.
- Serves hits from a direct-mapped, one-word-per-line icache.
- On a miss, issues a word request to the memory controller and waits for completion.
- Handles branch redirects from EX and drives the IF/ID flush.

Parameters:
- ICACHE_INDEX_W, 5, log2 of icache line count (32 lines); legal range 1..10.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high (`RstEnable)
- rdy  input  1  global ready; low freezes all state
- stall  input  6  pipeline stall vector; only stall[0] used
- branch_flag_i  input  1  EX redirect request
- branch_target_i  input  32  redirect PC
- mem_done_i  input  1  one-cycle pulse, fetched word valid
- mem_data_i  input  32  fetched word, little-endian assembled
- mem_req_o  output  1  word-fetch request (level)
- mem_addr_o  output  32  fetch address
- get_inst  output  1  if_pc / if_inst valid
- if_pc  output  32  PC of offered instruction
- if_inst  output  32  offered instruction
- if_idflush_o  output  1  flush to IF/ID register

Behaviour:
- Reset (async, rst=1) clears the following:
  - pc = 0, state = IDLE.
  - Output slot: out_valid = 0, out_pc = 0, out_inst = 0.
  - All icache valid bits = 0.
  - Resulting outputs: get_inst = 0, if_pc = 0, if_inst = 0, mem_req_o = 0, mem_addr_o = 0.
- rdy = 0: every register holds. Outputs stay as derived from held state. mem_done_i is ignored, so the controller must not pulse done while rdy = 0.
- Output slot:
  - get_inst = out_valid; if_pc = out_pc; if_inst = out_inst.
  - The slot is held until consumed. Consumption happens at a posedge where out_valid = 1 and stall[0] = NoStop.
  - "Slot free" means out_valid = 0, or the slot is being consumed this edge.
- States: IDLE, FETCH, FLUSH.
  - mem_req_o = (state == FETCH || state == FLUSH).
  - mem_addr_o = fetch-address register, loaded on IDLE→FETCH and stable while requesting.
- Icache addressing:
  - index = pc[ICACHE_INDEX_W+1:2]; tag = pc[31:ICACHE_INDEX_W+2].
  - Hit = valid[index] && tag match, evaluated combinationally on the current pc.
  - PCs are word-aligned; pc[1:0] is ignored.
- IDLE, slot free:
  - Hit: load slot with (pc, data), out_valid <= 1, pc <= pc + 4. Back-to-back hits give one instruction per cycle.
  - Miss: fetch addr <= pc, state <= FETCH; the slot empties if it was consumed.
  - Slot not free: hold.
- FETCH, on mem_done_i:
  - Write the line (valid, tag, data).
  - Load slot with (pc, mem_data_i), out_valid <= 1, pc <= pc + 4, state <= IDLE.
  - mem_req_o drops the cycle after done.
  - Miss-to-get_inst latency = controller latency + 2 cycles from the IDLE miss decision.
- FLUSH (outstanding request belonging to a squashed path):
  - On mem_done_i, write the line and discard the word; state <= IDLE.
- Redirect, branch_flag_i = 1 (highest priority, overrides everything above in that cycle):
  - pc <= branch_target_i, out_valid <= 0.
  - If state is FETCH or FLUSH and mem_done_i = 0: state <= FLUSH.
  - If mem_done_i = 1 in the same cycle: the cache is written, the word is discarded, state <= IDLE.
  - if_idflush_o = branch_flag_i, combinational.
- Pc arithmetic wraps modulo 2^32 (0xFFFFFFFC + 4 = 0).
- Reset mid-fetch drops the request immediately. The memory controller resets on the same rst.

Test Plan:
- Reset, then cold start at pc 0; controller returns 0x00000013 after 3 cycles → mem_req_o high with addr 0. Get_inst=1, if_pc=0, if_inst=0x00000013 one cycle after done; pc becomes 4.
- Loop re-executing addresses 0x0–0xC after first fill → four consecutive cycles of get_inst with if_pc 0,4,8,0xC, mem_req_o stays 0.
- Hold stall[0]=1 for 5 cycles while get_inst=1 at pc 0x8 → if_pc/if_inst constant, no pc advance, no new request. Release → next cycle if_pc=0xC.
- branch_flag_i=1, target 0x100, during FETCH of 0x40 → if_idflush_o=1 same cycle, state FLUSH. The 0x40 word is cached but never offered; next offered if_pc=0x100.
- Aliasing with ICACHE_INDEX_W=5: fetch 0x0 then 0x80 → second access misses and replaces the line; refetching 0x0 misses again.
- Assert rst while mem_req_o=1, plus rdy=0 for 3 cycles mid-hit-stream → immediate zeroed outputs and invalid cache. With rdy low, outputs are frozen and pc is unchanged.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, serves hits from a direct-mapped one-word-per-line
// icache, fetches misses from the memory controller and offers one instruction per slot.
//
// state    | meaning
// ST_IDLE  | no request outstanding; hits fill the slot, a miss launches a fetch
// ST_FETCH | request outstanding for pc; the returned word fills the cache and the slot
// ST_FLUSH | request outstanding for a squashed path; the word fills the cache only
module if_fetch #(
   parameter int ICACHE_INDEX_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        mem_done_i,
   input  logic [31:0] mem_data_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        get_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_idflush_o
);

   localparam int LINES = 1 << ICACHE_INDEX_W;
   localparam int TAG_W = 32 - ICACHE_INDEX_W - 2;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH} state_t;

   state_t                    state_q, state_n;
   logic [31:0]               pc_q, pc_n;
   logic [31:0]               fetch_addr_q, fetch_addr_n;
   logic                      out_valid_q, out_valid_n;
   logic [31:0]               out_pc_q, out_pc_n;
   logic [31:0]               out_inst_q, out_inst_n;
   logic [LINES-1:0]          valid_q;
   logic [TAG_W-1:0]          tag_mem [LINES];
   logic [31:0]               data_mem [LINES];

   logic [ICACHE_INDEX_W-1:0] pc_idx, fill_idx;
   logic [TAG_W-1:0]          pc_tag, fill_tag;
   logic                      hit, consume, slot_free, cache_we;
   logic                      unused_stall;

   assign unused_stall = ^stall[5:1];

   assign pc_idx    = pc_q[ICACHE_INDEX_W+1:2];
   assign pc_tag    = pc_q[31:ICACHE_INDEX_W+2];
   assign fill_idx  = fetch_addr_q[ICACHE_INDEX_W+1:2];
   assign fill_tag  = fetch_addr_q[31:ICACHE_INDEX_W+2];
   assign hit       = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign consume   = out_valid_q && !stall[0];
   assign slot_free = !out_valid_q || consume;

   assign mem_req_o    = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
   assign mem_addr_o   = fetch_addr_q;
   assign get_inst     = out_valid_q;
   assign if_pc        = out_pc_q;
   assign if_inst      = out_inst_q;
   assign if_idflush_o = branch_flag_i;

   always_comb begin
      state_n      = state_q;
      pc_n         = pc_q;
      fetch_addr_n = fetch_addr_q;
      out_valid_n  = out_valid_q && !consume;
      out_pc_n     = out_pc_q;
      out_inst_n   = out_inst_q;
      cache_we     = 1'b0;

      if (branch_flag_i) begin
         // Redirect wins; an in-flight request still completes into the cache.
         pc_n        = branch_target_i;
         out_valid_n = 1'b0;
         if (state_q != ST_IDLE) begin
            if (mem_done_i) begin
               cache_we = 1'b1;
               state_n  = ST_IDLE;
            end else begin
               state_n  = ST_FLUSH;
            end
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (slot_free) begin
                  if (hit) begin
                     out_valid_n = 1'b1;
                     out_pc_n    = pc_q;
                     out_inst_n  = data_mem[pc_idx];
                     pc_n        = pc_q + 32'd4;
                  end else begin
                     fetch_addr_n = pc_q;
                     state_n      = ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (mem_done_i) begin
                  cache_we    = 1'b1;
                  out_valid_n = 1'b1;
                  out_pc_n    = pc_q;
                  out_inst_n  = mem_data_i;
                  pc_n        = pc_q + 32'd4;
                  state_n     = ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (mem_done_i) begin
                  cache_we = 1'b1;
                  state_n  = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         fetch_addr_q <= '0;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_inst_q   <= '0;
         valid_q      <= '0;
      end else if (rdy) begin
         state_q      <= state_n;
         pc_q         <= pc_n;
         fetch_addr_q <= fetch_addr_n;
         out_valid_q  <= out_valid_n;
         out_pc_q     <= out_pc_n;
         out_inst_q   <= out_inst_n;
         if (cache_we) valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag/data arrays need no reset; the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (rdy && cache_we) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_data_i;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a small behavioural memory controller answers requests after
// a fixed latency; expected PCs and words come from the bench's own instruction table.
module tb_if_fetch;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic [5:0]  stall = '0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        mem_done_i = 1'b0;
   logic [31:0] mem_data_i = '0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        get_inst;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_idflush_o;

   int n_vec = 0;
   int n_err = 0;
   int mem_cnt = 0;

   if_fetch #(.ICACHE_INDEX_W(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .mem_done_i(mem_done_i), .mem_data_i(mem_data_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .get_inst(get_inst), .if_pc(if_pc), .if_inst(if_inst),
      .if_idflush_o(if_idflush_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0000_0013 : (32'hA000_0000 ^ a);
   endfunction

   // Memory controller model: done pulses LAT cycles after the request is first seen.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         mem_done_i = 1'b0;
         mem_cnt    = 0;
      end else if (rdy) begin
         if (mem_done_i) begin
            mem_done_i = 1'b0;
            mem_cnt    = 0;
         end else if (mem_req_o) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt == LAT) begin
               mem_done_i = 1'b1;
               mem_data_i = inst_of(mem_addr_o);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_get(input int max);
      int n = 0;
      while (!get_inst && n < max) begin
         step();
         n++;
      end
      check("get_inst_wait", {31'b0, get_inst}, 32'd1);
   endtask

   task automatic expect_slot(input string tag, input logic [31:0] pc);
      check({tag, "_pc"}, if_pc, pc);
      check({tag, "_inst"}, if_inst, inst_of(pc));
   endtask

   task automatic redirect(input logic [31:0] target);
      branch_flag_i   = 1'b1;
      branch_target_i = target;
      #1;
      check("idflush", {31'b0, if_idflush_o}, 32'd1);
      step();
      branch_flag_i = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      step();
      check("rst_get", {31'b0, get_inst}, 32'd0);
      check("rst_pc", if_pc, 32'h0);
      check("rst_inst", if_inst, 32'h0);
      check("rst_req", {31'b0, mem_req_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'h0);
      rst = 1'b0;

      // Cold start at pc 0
      step();
      check("cold_req", {31'b0, mem_req_o}, 32'd1);
      check("cold_addr", mem_addr_o, 32'h0);
      for (int i = 0; i < 20 && !mem_done_i; i++) step();
      check("cold_done", {31'b0, mem_done_i}, 32'd1);
      step();
      check("cold_get", {31'b0, get_inst}, 32'd1);
      expect_slot("cold", 32'h0);
      check("cold_req_drop", {31'b0, mem_req_o}, 32'd0);

      // Fill 4, 8, C by misses
      for (int a = 4; a <= 12; a += 4) begin
         step();
         wait_get(20);
         expect_slot("fill", 32'(a));
      end

      // Loop back to 0: four back-to-back hits
      redirect(32'h0);
      for (int a = 0; a <= 8; a += 4) begin
         step();
         check("loop_get", {31'b0, get_inst}, 32'd1);
         expect_slot("loop", 32'(a));
         check("loop_req", {31'b0, mem_req_o}, 32'd0);
      end

      // Stall holding slot 0x8 for 5 cycles
      stall[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_slot("stall", 32'h8);
         check("stall_req", {31'b0, mem_req_o}, 32'd0);
      end
      stall[0] = 1'b0;
      step();
      expect_slot("unstall", 32'hC);

      // Redirect during FETCH of 0x40
      redirect(32'h40);
      step();
      check("f40_req", {31'b0, mem_req_o}, 32'd1);
      check("f40_addr", mem_addr_o, 32'h40);
      redirect(32'h100);
      check("flush_req", {31'b0, mem_req_o}, 32'd1);
      check("flush_get", {31'b0, get_inst}, 32'd0);
      wait_get(30);
      expect_slot("after_flush", 32'h100);

      // The squashed 0x40 word was cached
      redirect(32'h40);
      step();
      check("c40_get", {31'b0, get_inst}, 32'd1);
      expect_slot("c40", 32'h40);
      check("c40_req", {31'b0, mem_req_o}, 32'd0);

      // Aliasing: 0x80 evicts 0x0
      redirect(32'h80);
      step();
      check("alias80_req", {31'b0, mem_req_o}, 32'd1);
      check("alias80_addr", mem_addr_o, 32'h80);
      wait_get(20);
      expect_slot("alias80", 32'h80);
      redirect(32'h0);
      step();
      check("alias0_req", {31'b0, mem_req_o}, 32'd1);
      check("alias0_addr", mem_addr_o, 32'h0);
      wait_get(20);
      expect_slot("alias0", 32'h0);

      // rdy low mid hit stream
      step();
      expect_slot("prerdy", 32'h4);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rdy_get", {31'b0, get_inst}, 32'd1);
         expect_slot("rdy_hold", 32'h4);
      end
      rdy = 1'b1;
      step();
      expect_slot("rdy_resume", 32'h8);
      step();
      expect_slot("rdy_next", 32'hC);

      // Reset during a fetch of 0x10
      step();
      check("f10_req", {31'b0, mem_req_o}, 32'd1);
      check("f10_addr", mem_addr_o, 32'h10);
      rst = 1'b1;
      #1;
      check("mrst_req", {31'b0, mem_req_o}, 32'd0);
      check("mrst_get", {31'b0, get_inst}, 32'd0);
      check("mrst_pc", if_pc, 32'h0);
      check("mrst_addr", mem_addr_o, 32'h0);
      step();
      rst = 1'b0;
      step();
      check("cold2_req", {31'b0, mem_req_o}, 32'd1);
      check("cold2_addr", mem_addr_o, 32'h0);
      wait_get(20);
      expect_slot("cold2", 32'h0);

      // PC wrap: 0xFFFFFFFC + 4 = 0 (0 is cached again)
      redirect(32'hFFFF_FFFC);
      wait_get(20);
      expect_slot("wrap_top", 32'hFFFF_FFFC);
      step();
      wait_get(20);
      expect_slot("wrap_zero", 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
